// File: rtl/conv_row_sequencer.sv
// conv_row_sequencer: row-level controller stepping the conv datapath.
// Pulls kernel/matrix rows, issues conv_clear/conv_step, emits result rows.
// Ports: job (start, num_rows, busy, done, err); kernel/matrix row sources
// (valid/ready); datapath strobes and streams; result row sink with last.
// Optional: define CONV_SEQ_STATS_EN to add stall_count (FILL/STREAM
// cycles without a step, saturating, cleared on an accepted start).
module conv_row_sequencer #(
  parameter int MATRIX_WIDTH    = 9,
  parameter int KERNEL_WIDTH    = 3,
  parameter int KERNEL_HEIGHT   = 3,
  parameter int DATA_SIZE       = 256,
  parameter int ROW_COUNT_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [ROW_COUNT_WIDTH-1:0]          num_rows,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  input  logic [DATA_SIZE*KERNEL_WIDTH-1:0]   kernel_row_data,
  input  logic                                kernel_row_valid,
  output logic                                kernel_row_ready,
  input  logic [DATA_SIZE*MATRIX_WIDTH-1:0]   matrix_row_data,
  input  logic                                matrix_row_valid,
  output logic                                matrix_row_ready,
  output logic [DATA_SIZE*KERNEL_WIDTH-1:0]   conv_kernel_stream,
  output logic [DATA_SIZE*MATRIX_WIDTH-1:0]   conv_matrix_stream,
  output logic                                conv_step,
  output logic                                conv_clear,
  input  logic [DATA_SIZE*MATRIX_WIDTH-1:0]   conv_result,
  output logic [DATA_SIZE*MATRIX_WIDTH-1:0]   out_row_data,
  output logic                                out_row_valid,
  input  logic                                out_row_ready,
  output logic                                out_row_last
`ifdef CONV_SEQ_STATS_EN
  ,
  output logic [15:0]                         stall_count
`endif
);

  localparam int RCW = ROW_COUNT_WIDTH;
  localparam logic [RCW-1:0] KH    = RCW'(KERNEL_HEIGHT);
  localparam logic [RCW-1:0] KH_M1 = RCW'(KERNEL_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [RCW-1:0] r_h;
  logic [RCW-1:0] r_row;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic           r_clear;
  logic           r_ovalid;
  logic           r_olast;

  logic w_slot_ok;
  logic w_fill;
  logic w_stream;
  logic w_step;
  logic w_last_step;
  logic w_produce;
  logic w_hs;

  // A new step may only fire when the result register is free or
  // is being drained this same cycle.
  assign w_slot_ok   = !r_ovalid || out_row_ready;
  assign w_fill      = (r_state == S_FILL);
  assign w_stream    = (r_state == S_STREAM);
  assign w_step      = w_slot_ok && matrix_row_valid &&
                       ((w_fill && kernel_row_valid) || w_stream);
  assign w_last_step = (r_row == r_h - 1'b1);
  assign w_produce   = w_step && (r_row >= KH_M1);
  assign w_hs        = r_ovalid && out_row_ready;

  assign kernel_row_ready   = w_fill && w_step;
  assign matrix_row_ready   = w_step;
  assign conv_step          = w_step;
  assign conv_kernel_stream = (w_fill && w_step) ? kernel_row_data : '0;
  assign conv_matrix_stream = w_step ? matrix_row_data : '0;
  assign conv_clear         = r_clear;
  assign busy               = r_busy;
  assign done               = r_done;
  assign err                = r_err;
  assign out_row_data       = conv_result;
  assign out_row_valid      = r_ovalid;
  assign out_row_last       = r_olast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_h      <= '0;
      r_row    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_clear  <= 1'b0;
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_clear <= 1'b0;
      // A producing step refills the slot in the same cycle it drains.
      if (w_produce) begin
        r_ovalid <= 1'b1;
        r_olast  <= w_last_step;
      end else if (w_hs) begin
        r_ovalid <= 1'b0;
        r_olast  <= 1'b0;
      end
      if (w_step) r_row <= r_row + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_rows >= KH) begin
              r_h     <= num_rows;
              r_row   <= '0;
              r_busy  <= 1'b1;
              r_clear <= 1'b1;
              r_state <= S_CLEAR;
            end else begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_CLEAR: r_state <= S_FILL;
        S_FILL: begin
          if (w_step && r_row == KH_M1)
            r_state <= w_last_step ? S_FLUSH : S_STREAM;
        end
        S_STREAM: begin
          if (w_step && w_last_step) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (w_hs && r_olast) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CONV_SEQ_STATS_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (r_state == S_IDLE && start && num_rows >= KH) begin
      r_stall <= '0;
    end else if ((w_fill || w_stream) && !w_step &&
                 r_stall != 16'hFFFF) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_count = r_stall;
`endif

endmodule
